reg_file_nrw: RTL and testbench

Parametrised multi-entry register bank for the multi-clock CPU datapath, generalising the single 32-bit load-enabled register to DEPTH entries of WIDTH bits. It provides one byte-enabled write port, two asynchronous read ports, optional write-to-read bypass and a hardwired-zero entry 0, so one block serves as the general-purpose register file and as a bank of pipeline holding registers. State is cleared asynchronously at reset and can also be cleared synchronously in bulk.

---
 rtl/reg_file_nrw_if.sv | 26 ++
 rtl/reg_file_nrw.sv | 84 ++++++++
 tb/tb_reg_file_nrw.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_nrw_if.sv
// Write/read bus for the reg_file_nrw register bank.
// master drives addresses, data and controls; slave returns read data.
interface reg_file_nrw_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic               clr;
    logic               we;
    logic [WIDTH/8-1:0] be;
    logic [AW-1:0]      wa;
    logic [WIDTH-1:0]   wd;
    logic [AW-1:0]      ra1;
    logic [AW-1:0]      ra2;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;

    modport master (
        output clr, we, be, wa, wd, ra1, ra2,
        input  rd1, rd2
    );

    modport slave (
        input  clr, we, be, wa, wd, ra1, ra2,
        output rd1, rd2
    );
endinterface

// File: rtl/reg_file_nrw.sv
// DEPTH x WIDTH register bank: byte-enabled write port, two async reads,
// optional write bypass and hardwired-zero entry 0.
module reg_file_nrw #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            cl,
    input logic            cr,
    reg_file_nrw_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wa_ok;
    logic             wr_ok;
    logic             fwd;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_new;
    logic [AW-1:0]    ra [2];
    logic [WIDTH-1:0] rd [2];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW + 1)'(DEPTH);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wa_ok = in_range(bus.wa) && !is_zero(bus.wa);
    assign wr_ok = cr && bus.we && !bus.clr && wa_ok;
    assign fwd   = (BYPASS != 0) && wr_ok;

    // Post-write image of the target entry; shared by storage and bypass
    always_comb begin
        wr_old = '0;
        if (in_range(bus.wa)) begin
            wr_old = mem[bus.wa];
        end
        wr_new = wr_old;
        for (int k = 0; k < NB; k++) begin
            if (bus.be[k]) begin
                wr_new[8*k +: 8] = bus.wd[8*k +: 8];
            end
        end
    end

    always_ff @(posedge cl or negedge cr) begin
        if (!cr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wa] <= wr_new;
        end
    end

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = '0;
            if (!cr) begin
                rd[p] = '0;
            end else if (fwd && (ra[p] == bus.wa)) begin
                rd[p] = wr_new;
            end else if (in_range(ra[p]) && !is_zero(ra[p])) begin
                rd[p] = mem[ra[p]];
            end
        end
    end

    assign bus.rd1 = rd[0];
    assign bus.rd2 = rd[1];
endmodule

// File: tb/tb_reg_file_nrw.sv
// Directed test for reg_file_nrw: a default instance (bypass, 32 entries)
// and a DEPTH=20 instance without bypass share clock and reset.
module tb_reg_file_nrw;
    logic cl;
    logic cr;
    int   nasrt;
    int   nfail;

    reg_file_nrw_if #(.WIDTH(32), .AW(5)) ia ();
    reg_file_nrw_if #(.WIDTH(32), .AW(5)) ib ();

    reg_file_nrw dut_a (
        .cl  (cl),
        .cr  (cr),
        .bus (ia.slave)
    );

    reg_file_nrw #(
        .WIDTH    (32),
        .DEPTH    (20),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) dut_b (
        .cl  (cl),
        .cr  (cr),
        .bus (ib.slave)
    );

    initial cl = 1'b0;
    always #5 cl = ~cl;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nasrt++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        ia.we = 1'b0; ia.clr = 1'b0; ia.be = 4'h0;
        ia.wa = '0;   ia.wd = '0;
    endtask

    task automatic idle_b();
        ib.we = 1'b0; ib.clr = 1'b0; ib.be = 4'h0;
        ib.wa = '0;   ib.wd = '0;
    endtask

    initial begin
        nasrt = 0;
        nfail = 0;
        idle_a();
        idle_b();
        ia.ra1 = '0; ia.ra2 = '0;
        ib.ra1 = '0; ib.ra2 = '0;
        cr = 1'b1;
        #1 cr = 1'b0;

        // reset: random read addresses, write attempted during reset
        ia.ra1 = 5'd13; ia.ra2 = 5'd27;
        ia.we = 1'b1; ia.wa = 5'd5; ia.wd = 32'hDEADBEEF; ia.be = 4'hF;
        #1;
        chk("rst_rd1", ia.rd1, 32'h0);
        chk("rst_rd2", ia.rd2, 32'h0);
        ia.ra1 = 5'd5;
        @(posedge cl); #1;
        chk("rst_wr_rd1", ia.rd1, 32'h0);
        @(negedge cl);
        idle_a();
        cr = 1'b1;
        #1 chk("rst_after_e5", ia.rd1, 32'h0);

        // full write then partial byte write to entry 3
        @(negedge cl);
        ia.we = 1'b1; ia.wa = 5'd3; ia.wd = 32'h11223344; ia.be = 4'hF;
        @(negedge cl);
        ia.wd = 32'hAABBCCDD; ia.be = 4'b0101;
        @(negedge cl);
        idle_a();
        ia.ra1 = 5'd3;
        #1 chk("byte_wr", ia.rd1, 32'h11BB33DD);

        // zero entry ignores writes and is not bypassed
        ia.we = 1'b1; ia.wa = 5'd0; ia.wd = 32'hFFFFFFFF; ia.be = 4'hF;
        ia.ra1 = 5'd0;
        #1 chk("zero_pre", ia.rd1, 32'h0);
        @(negedge cl);
        idle_a();
        #1 chk("zero_post", ia.rd1, 32'h0);

        // DEPTH=20: last legal entry, then out-of-range write
        ib.we = 1'b1; ib.wa = 5'd19; ib.wd = 32'h13; ib.be = 4'hF;
        @(negedge cl);
        ib.wa = 5'd25; ib.wd = 32'h77777777;
        ib.ra1 = 5'd19; ib.ra2 = 5'd25;
        @(negedge cl);
        idle_b();
        #1;
        chk("b_last", ib.rd1, 32'h13);
        chk("b_oor", ib.rd2, 32'h0);
        ib.ra2 = 5'd20;
        #1 chk("b_ra20", ib.rd2, 32'h0);

        // bypass: entry 7 in both banks, then partial write with ra=wa
        ia.we = 1'b1; ia.wa = 5'd7; ia.wd = 32'h12345678; ia.be = 4'hF;
        ib.we = 1'b1; ib.wa = 5'd7; ib.wd = 32'h12345678; ib.be = 4'hF;
        @(negedge cl);
        ia.wd = 32'hCAFEF00D; ia.be = 4'b0011;
        ib.wd = 32'hCAFEF00D; ib.be = 4'b0011;
        ia.ra1 = 5'd7; ia.ra2 = 5'd7;
        ib.ra1 = 5'd7; ib.ra2 = 5'd7;
        #1;
        chk("byp_pre_rd1", ia.rd1, 32'h1234F00D);
        chk("byp_pre_rd2", ia.rd2, 32'h1234F00D);
        chk("nobyp_pre", ib.rd1, 32'h12345678);
        @(negedge cl);
        idle_a();
        idle_b();
        #1;
        chk("byp_post", ia.rd1, 32'h1234F00D);
        chk("nobyp_post", ib.rd2, 32'h1234F00D);

        // we with no byte enables is a no-op, bypass included
        ia.we = 1'b1; ia.wa = 5'd7; ia.wd = 32'hFFFFFFFF; ia.be = 4'h0;
        #1 chk("be0_pre", ia.rd1, 32'h1234F00D);
        @(negedge cl);
        idle_a();
        #1 chk("be0_post", ia.rd1, 32'h1234F00D);

        // fill 1..31 with index
        for (int i = 1; i < 32; i++) begin
            ia.we = 1'b1; ia.wa = 5'(i); ia.wd = 32'(i); ia.be = 4'hF;
            @(negedge cl);
        end
        idle_a();
        ia.ra1 = 5'd31; ia.ra2 = 5'd9;
        #1;
        chk("fill_31", ia.rd1, 32'd31);
        chk("fill_9", ia.rd2, 32'd9);

        // clr beats a simultaneous write and suppresses bypass
        ia.clr = 1'b1; ia.we = 1'b1; ia.wa = 5'd9; ia.wd = 32'h55;
        ia.be = 4'hF;
        #1 chk("clr_pre_nobyp", ia.rd2, 32'd9);
        @(negedge cl);
        idle_a();
        for (int i = 0; i < 32; i++) begin
            ia.ra1 = 5'(i);
            #1 chk($sformatf("clr_e%0d", i), ia.rd1, 32'h0);
        end

        // async reset between edges
        @(negedge cl);
        ia.we = 1'b1; ia.wa = 5'd4; ia.wd = 32'hA5A5A5A5; ia.be = 4'hF;
        @(negedge cl);
        idle_a();
        ia.ra1 = 5'd4;
        #1 chk("ar_before", ia.rd1, 32'hA5A5A5A5);
        #1 cr = 1'b0;
        #1 chk("ar_low", ia.rd1, 32'h0);
        cr = 1'b1;
        #1 chk("ar_released", ia.rd1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end
endmodule
